// File: rtl/result_pipe_pkg.sv
// Shared constants and the pipeline entry type for the result pipe.
// A stage-index helper keeps the ready rule in one place.
package result_pipe_pkg;

  localparam int DEPTH  = 7;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  localparam int LAT_W  = 3;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [ADDR_W-1:0] rt;
    logic [LAT_W-1:0]  lat;
    logic [DATA_W-1:0] data;
  } pipe_entry_t;

  // stage_idx is 0-based (stage 1 == index 0); the last stage is always ready,
  // which clamps latency codes of DEPTH or more.
  function automatic logic entry_ready(input int stage_idx, input logic [LAT_W-1:0] lat);
    return (stage_idx == DEPTH - 1) || (stage_idx >= int'(lat));
  endfunction

endpackage

// File: rtl/result_pipe_fwd_lookup.sv
// Per-operand forwarding lookup: finds the youngest writing entry for one
// read address and reports hit/data or a hazard if that entry is not ready.
module fwd_lookup
  import result_pipe_pkg::*;
(
  input  pipe_entry_t [DEPTH-1:0] i_stages,
  input  logic [ADDR_W-1:0]       i_rd_addr,
  output logic                    o_hit,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_hazard
);

  logic              w_found;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    w_found = 1'b0;
    w_ready = 1'b0;
    w_data  = '0;
    // Walk oldest to youngest; blocking writes let the youngest match win.
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (i_stages[s].valid && i_stages[s].wr && (i_stages[s].rt == i_rd_addr)) begin
        w_found = 1'b1;
        w_ready = entry_ready(s, i_stages[s].lat);
        w_data  = i_stages[s].data;
      end
    end
  end

  assign o_hit    = w_found & w_ready;
  assign o_data   = (w_found & w_ready) ? w_data : '0;
  assign o_hazard = w_found & ~w_ready;

endmodule

// File: rtl/result_pipe.sv
// Fixed-depth in-order result pipeline: writeback from the last stage,
// with three forwarding/hazard lookups for the register-read stage.
module result_pipe
  import result_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic [ADDR_W-1:0] in_rt_addr,
  input  logic [DATA_W-1:0] in_result,
  input  logic [LAT_W-1:0]  in_latency,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] rd_addr_c,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic              fwd_hit_c,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic [DATA_W-1:0] fwd_data_c,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              hazard_c,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  pipe_entry_t [DEPTH-1:0] r_stages;
  pipe_entry_t             w_in;

  always_comb begin
    w_in = '0;
    if (in_valid) begin
      w_in.valid = 1'b1;
      w_in.wr    = in_reg_write;
      w_in.rt    = in_rt_addr;
      w_in.lat   = in_latency;
      w_in.data  = in_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the whole stage array is reset, not just valid bits, because
      // wb_addr/wb_data come straight from the last stage and must read 0.
      r_stages <= '0;
    end else begin
      // NOTE: non-blocking assignment so every stage shifts from the old value.
      r_stages <= {r_stages[DEPTH-2:0], w_in};
    end
  end

  assign wb_valid = r_stages[DEPTH-1].valid & r_stages[DEPTH-1].wr;
  assign wb_addr  = r_stages[DEPTH-1].rt;
  assign wb_data  = r_stages[DEPTH-1].data;

  fwd_lookup u_lookup_a (
    .i_stages (r_stages),
    .i_rd_addr(rd_addr_a),
    .o_hit    (fwd_hit_a),
    .o_data   (fwd_data_a),
    .o_hazard (hazard_a)
  );

  fwd_lookup u_lookup_b (
    .i_stages (r_stages),
    .i_rd_addr(rd_addr_b),
    .o_hit    (fwd_hit_b),
    .o_data   (fwd_data_b),
    .o_hazard (hazard_b)
  );

  fwd_lookup u_lookup_c (
    .i_stages (r_stages),
    .i_rd_addr(rd_addr_c),
    .o_hit    (fwd_hit_c),
    .o_data   (fwd_data_c),
    .o_hazard (hazard_c)
  );

endmodule

// File: tb/tb_result_pipe.sv
// Self-checking bench for result_pipe: writeback scoreboard plus directed
// forwarding/hazard expectations and an asynchronous mid-stream reset.
module tb_result_pipe;
  import result_pipe_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_reg_write;
  logic [ADDR_W-1:0] in_rt_addr;
  logic [DATA_W-1:0] in_result;
  logic [LAT_W-1:0]  in_latency;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, rd_addr_c;
  logic              fwd_hit_a, fwd_hit_b, fwd_hit_c;
  logic [DATA_W-1:0] fwd_data_a, fwd_data_b, fwd_data_c;
  logic              hazard_a, hazard_b, hazard_c;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  result_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_reg_write(in_reg_write),
    .in_rt_addr  (in_rt_addr),
    .in_result   (in_result),
    .in_latency  (in_latency),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_addr_c   (rd_addr_c),
    .fwd_hit_a   (fwd_hit_a),
    .fwd_hit_b   (fwd_hit_b),
    .fwd_hit_c   (fwd_hit_c),
    .fwd_data_a  (fwd_data_a),
    .fwd_data_b  (fwd_data_b),
    .fwd_data_c  (fwd_data_c),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .hazard_c    (hazard_c),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_exp_t;

  wb_exp_t wb_q[$];
  int      n_total = 0;
  int      n_bad   = 0;
  int      cyc     = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d: got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_fwd(input string tag, input logic hit, input logic [DATA_W-1:0] data,
                         input logic haz, input logic e_hit, input logic [DATA_W-1:0] e_data,
                         input logic e_haz);
    check({tag, "_hit"}, DATA_W'(hit), DATA_W'(e_hit));
    check({tag, "_data"}, data, e_data);
    check({tag, "_haz"}, DATA_W'(haz), DATA_W'(e_haz));
  endtask

  task automatic drive(input logic wr, input logic [ADDR_W-1:0] rt,
                       input logic [LAT_W-1:0] lat, input logic [DATA_W-1:0] data);
    wb_exp_t e;
    in_valid     = 1'b1;
    in_reg_write = wr;
    in_rt_addr   = rt;
    in_latency   = lat;
    in_result    = data;
    if (wr) begin
      e.cyc  = cyc + DEPTH;
      e.addr = rt;
      e.data = data;
      wb_q.push_back(e);
    end
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    in_reg_write = 1'b0;
    in_rt_addr   = '0;
    in_latency   = '0;
    in_result    = '0;
  endtask

  // Compare writeback against the scoreboard, then advance one cycle.
  task automatic step();
    if (wb_q.size() > 0 && wb_q[0].cyc == cyc) begin
      check("wb_valid", DATA_W'(wb_valid), DATA_W'(1'b1));
      check("wb_addr", DATA_W'(wb_addr), DATA_W'(wb_q[0].addr));
      check("wb_data", wb_data, wb_q[0].data);
      void'(wb_q.pop_front());
    end else begin
      check("wb_idle", DATA_W'(wb_valid), '0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [DATA_W-1:0] d;
  logic              eh, ez;

  initial begin
    rst_n = 1'b0;
    idle();
    rd_addr_a = 7'd100;
    rd_addr_b = 7'd101;
    rd_addr_c = 7'd102;
    #12;
    check("rst_wb_valid", DATA_W'(wb_valid), '0);
    check("rst_wb_addr", DATA_W'(wb_addr), '0);
    check("rst_wb_data", wb_data, '0);
    chk_fwd("rst_a", fwd_hit_a, fwd_data_a, hazard_a, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;

    // lat=2: hazard in cycles 1-2, forwardable 3-7, writeback in 7.
    d = 128'hAAAA;
    for (int k = 0; k <= 8; k++) begin
      if (k == 0) drive(1'b1, 7'd5, 3'd2, d);
      else idle();
      rd_addr_a = 7'd5;
      #1;
      eh = (k >= 3 && k <= 7);
      ez = (k >= 1 && k <= 2);
      chk_fwd("t1_a", fwd_hit_a, fwd_data_a, hazard_a, eh, eh ? d : '0, ez);
      step();
    end

    // Younger unready entry shadows an older ready one.
    for (int k = 0; k <= 9; k++) begin
      if (k == 0) drive(1'b1, 7'd9, 3'd0, 128'd1);
      else if (k == 1) drive(1'b1, 7'd9, 3'd5, 128'd2);
      else idle();
      rd_addr_b = 7'd9;
      #1;
      eh = (k >= 1 && k <= 1) || (k >= 7 && k <= 8);
      ez = (k >= 2 && k <= 6);
      d  = (k == 1) ? 128'd1 : 128'd2;
      chk_fwd("t2_b", fwd_hit_b, fwd_data_b, hazard_b, eh, eh ? d : '0, ez);
      step();
    end

    // Non-writing instruction: invisible to lookup and writeback.
    for (int k = 0; k <= 8; k++) begin
      if (k == 0) drive(1'b0, 7'd3, 3'd0, 128'h3333);
      else idle();
      rd_addr_c = 7'd3;
      #1;
      chk_fwd("t3_c", fwd_hit_c, fwd_data_c, hazard_c, 1'b0, '0, 1'b0);
      step();
    end

    // lat=7 is clamped: ready only in the last stage, the writeback cycle.
    d = 128'h777;
    for (int k = 0; k <= 8; k++) begin
      if (k == 0) drive(1'b1, 7'd20, 3'd7, d);
      else idle();
      rd_addr_a = 7'd20;
      #1;
      eh = (k == 7);
      ez = (k >= 1 && k <= 6);
      chk_fwd("t4_a", fwd_hit_a, fwd_data_a, hazard_a, eh, eh ? d : '0, ez);
      step();
    end

    // Back-to-back issue; the scoreboard demands gapless in-order writeback.
    rd_addr_a = 7'd100;
    rd_addr_b = 7'd101;
    rd_addr_c = 7'd102;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 7'(30 + i), 3'($urandom_range(0, 7)),
            {$urandom, $urandom, $urandom, 32'(i)});
      step();
    end
    for (int k = 0; k < DEPTH + 1; k++) begin
      idle();
      step();
    end

    // Fill four entries, then reset asynchronously between edges.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'(40 + i), (i == 3) ? 3'd7 : 3'd0, 128'h4000 + 128'(i));
      step();
    end
    idle();
    rd_addr_a = 7'd40;
    rd_addr_b = 7'd43;
    #1;
    chk_fwd("t6_pre_a", fwd_hit_a, fwd_data_a, hazard_a, 1'b1, 128'h4000, 1'b0);
    chk_fwd("t6_pre_b", fwd_hit_b, fwd_data_b, hazard_b, 1'b0, '0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_fwd("t6_rst_a", fwd_hit_a, fwd_data_a, hazard_a, 1'b0, '0, 1'b0);
    chk_fwd("t6_rst_b", fwd_hit_b, fwd_data_b, hazard_b, 1'b0, '0, 1'b0);
    check("t6_rst_wb_valid", DATA_W'(wb_valid), '0);
    check("t6_rst_wb_addr", DATA_W'(wb_addr), '0);
    check("t6_rst_wb_data", wb_data, '0);
    #1;
    rst_n = 1'b1;
    wb_q.delete();
    for (int k = 0; k < DEPTH + 3; k++) begin
      step();
      chk_fwd("t6_post_a", fwd_hit_a, fwd_data_a, hazard_a, 1'b0, '0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
